// File: rtl/mips_pkg.sv
// Shared opcodes, sequencer states and completion codes for the MIPS load/store unit.
package mips_pkg;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        MEM,
        WB,
        DONE,
        ERR
    } lsu_state_t;

    // Sign-extend a 16-bit immediate to a 32-bit offset.
    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_lsu_ctrl_if.sv
// Data-memory request/acknowledge port between the load/store unit and memory.
interface mips_lsu_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_agu.sv
// Address generation: base + sign-extended immediate, alignment and opcode checks.
module lsu_agu
    import mips_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [15:0] imm,
    input  logic [31:0] base,
    output logic [31:0] addr,
    output logic        misaligned,
    output logic        illegal,
    output logic        is_sw
);

    // Effective address wraps modulo 2^32; only word accesses are legal.
    always_comb begin
        addr       = base + sext16(imm);
        misaligned = |addr[1:0];
        illegal    = !((op == OP_LW) || (op == OP_SW));
        is_sw      = (op == OP_SW);
    end

endmodule

// File: rtl/mips_lsu_ctrl.sv
// Multi-cycle LW/SW sequencer: decode, memory handshake with timeout, writeback.
module mips_lsu_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    mips_lsu_ctrl_if.master   mem,
    output logic              done,
    output logic [1:0]        err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Last MEM cycle index at which an ack is still accepted.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state_q;
    logic [31:0]       instr_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              instr_ready_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              rf_we_q;
    logic              done_q;
    logic [1:0]        err_q;

    logic [31:0]       agu_addr;
    logic              agu_misaligned;
    logic              agu_illegal;
    logic              agu_is_sw;
    logic [4:0]        rt;

    assign rt = instr_q[20:16];

    lsu_agu u_agu (
        .op         (instr_q[31:26]),
        .imm        (instr_q[15:0]),
        .base       (rf_rdata_a[31:0]),
        .addr       (agu_addr),
        .misaligned (agu_misaligned),
        .illegal    (agu_illegal),
        .is_sw      (agu_is_sw)
    );

    assign instr_ready   = instr_ready_q;
    assign rf_raddr_a    = REG_AW'(instr_q[25:21]);
    assign rf_raddr_b    = REG_AW'(rt);
    assign rf_we         = rf_we_q;
    assign rf_waddr      = REG_AW'(rt);
    assign rf_wdata      = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign done          = done_q;
    assign err           = err_q;

    // Sequencer state, wait counter and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            instr_ready_q <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= ERR_OK;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q       <= instr;
                        instr_ready_q <= 1'b0;
                        state_q       <= DECODE;
                    end
                end
                DECODE: begin
                    addr_q  <= agu_addr;
                    wdata_q <= rf_rdata_b;
                    if (agu_illegal) begin
                        err_q   <= ERR_ILLEGAL;
                        done_q  <= 1'b1;
                        state_q <= ERR;
                    end else if (agu_misaligned) begin
                        err_q   <= ERR_MISALIGN;
                        done_q  <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= agu_is_sw;
                        cnt_q     <= '0;
                        state_q   <= MEM;
                    end
                end
                MEM: begin
                    // Ack is checked first so an ack on the final permitted cycle succeeds.
                    if (mem.mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (mem_we_q) begin
                            err_q   <= ERR_OK;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rdata_q <= mem.mem_rdata;
                            rf_we_q <= (rt != 5'd0);
                            state_q <= WB;
                        end
                    end else if (cnt_q == LIMIT) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= ERR_TIMEOUT;
                        done_q    <= 1'b1;
                        state_q   <= ERR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WB: begin
                    rf_we_q <= 1'b0;
                    err_q   <= ERR_OK;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE, ERR: begin
                    done_q        <= 1'b0;
                    err_q         <= ERR_OK;
                    instr_ready_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_lsu_ctrl.sv
// Self-checking bench for mips_lsu_ctrl: directed vector table, reset-abort sequence and
// randomized operations checked against a transaction-level model of regfile and memory.
module tb_mips_lsu_ctrl;

    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rf_raddr_a;
    logic [4:0]  rf_raddr_b;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;
    logic [1:0]  err;

    logic [31:0] rf [32];
    logic [31:0] dmem [logic [31:0]];

    int n_tests = 0;
    int n_fail  = 0;

    mips_lsu_ctrl_if #(.DATA_W(32)) mif ();

    mips_lsu_ctrl #(
        .DATA_W  (32),
        .REG_AW  (5),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .mem         (mif),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    typedef struct {
        int          err;
        int          done_cycle;
        int          req_first;
        int          req_cycles;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rfwe_cycle;
        logic [4:0]  waddr;
        logic [31:0] rf_wdata;
    } exp_t;

    typedef struct {
        exp_t v;
        int   done_count;
        int   rfwe_count;
        bit   stable;
        bit   ready_busy;
        bit   ready_after;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        int          waits;
        bit          spur;
        exp_t        e;
    } vec_t;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (dmem.exists(a)) return dmem[a];
        return ~a;
    endfunction

    function automatic exp_t mk(input int er, input int dc, input int rq, input int rc,
                                input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input int rw, input logic [4:0] wa, input logic [31:0] rd);
        exp_t e;
        e.err = er; e.done_cycle = dc; e.req_first = rq; e.req_cycles = rc;
        e.we = w; e.addr = a; e.wdata = wd;
        e.rfwe_cycle = rw; e.waddr = wa; e.rf_wdata = rd;
        return e;
    endfunction

    // Transaction-level model: what one instruction should do, given waits before ack.
    function automatic exp_t ref_model(input logic [31:0] ins, input int waits);
        exp_t    e;
        int      rs;
        int      rt;
        shortint offs;
        e = mk(0, -1, -1, 0, 1'b0, 32'h0, 32'h0, -1, 5'd0, 32'h0);
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        offs = shortint'(ins[15:0]);
        if (ins[31:26] != 6'h23 && ins[31:26] != 6'h2B) begin
            e.err = 1; e.done_cycle = 2;
            return e;
        end
        e.addr = rf[rs] + 32'(int'(offs));
        if (e.addr % 4 != 0) begin
            e.err = 2; e.done_cycle = 2;
            return e;
        end
        e.req_first = 2;
        e.we = (ins[31:26] == 6'h2B);
        e.wdata = rf[rt];
        if (waits >= TIMEOUT) begin
            e.err = 3; e.req_cycles = TIMEOUT; e.done_cycle = 2 + TIMEOUT;
            return e;
        end
        e.req_cycles = waits + 1;
        if (e.we) begin
            e.done_cycle = 3 + waits;
        end else begin
            e.done_cycle = 4 + waits;
            if (rt != 0) begin
                e.rfwe_cycle = 3 + waits;
                e.waddr = 5'(rt);
                e.rf_wdata = mem_read(e.addr);
            end
        end
        return e;
    endfunction

    // Commit the modelled side effects to the environment regfile/memory.
    task automatic apply_ref(input exp_t e);
        if (e.err == 0) begin
            if (e.we) dmem[e.addr] = e.wdata;
            else if (e.rfwe_cycle >= 0) rf[e.waddr] = e.rf_wdata;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one instruction at a negedge and act as a memory that acks after 'waits' cycles.
    task automatic run_op(input logic [31:0] ins, input int waits, input bit spur,
                          output obs_t o);
        int m;
        o.v = mk(-1, -1, -1, 0, 1'b0, 32'h0, 32'h0, -1, 5'd0, 32'h0);
        o.done_count = 0; o.rfwe_count = 0;
        o.stable = 1'b1; o.ready_busy = 1'b0; o.ready_after = 1'b0;
        m = 0;
        instr = ins;
        instr_valid = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clock);
            instr_valid = 1'b0;
            instr = $urandom();
            if (mif.mem_req) begin
                if (o.v.req_first < 0) begin
                    o.v.req_first = cyc;
                    o.v.we = mif.mem_we;
                    o.v.addr = mif.mem_addr;
                    o.v.wdata = mif.mem_wdata;
                end else if (mif.mem_we !== o.v.we || mif.mem_addr !== o.v.addr ||
                             mif.mem_wdata !== o.v.wdata) begin
                    o.stable = 1'b0;
                end
                o.v.req_cycles++;
                mif.mem_ack = (m == waits);
                mif.mem_rdata = (m == waits) ? mem_read(mif.mem_addr) : $urandom();
                m++;
            end else begin
                mif.mem_ack = spur;
                mif.mem_rdata = $urandom();
            end
            if (rf_we) begin
                o.rfwe_count++;
                if (o.v.rfwe_cycle < 0) begin
                    o.v.rfwe_cycle = cyc;
                    o.v.waddr = rf_waddr;
                    o.v.rf_wdata = rf_wdata;
                end
            end
            if (o.v.done_cycle < 0 && instr_ready) o.ready_busy = 1'b1;
            if (done) begin
                o.done_count++;
                if (o.v.done_cycle < 0) begin
                    o.v.done_cycle = cyc;
                    o.v.err = int'(err);
                end
            end
            if (o.v.done_cycle >= 0 && cyc == o.v.done_cycle + 1) begin
                o.ready_after = instr_ready;
                break;
            end
        end
        mif.mem_ack = 1'b0;
    endtask

    task automatic check_op(input string tag, input obs_t o, input exp_t e);
        cmp({tag, ".err"}, 32'(o.v.err), 32'(e.err));
        cmp({tag, ".done_cycle"}, 32'(o.v.done_cycle), 32'(e.done_cycle));
        cmp({tag, ".done_pulses"}, 32'(o.done_count), 32'd1);
        cmp({tag, ".req_first"}, 32'(o.v.req_first), 32'(e.req_first));
        cmp({tag, ".req_cycles"}, 32'(o.v.req_cycles), 32'(e.req_cycles));
        cmp({tag, ".ready_busy"}, {31'b0, o.ready_busy}, 32'd0);
        cmp({tag, ".ready_after"}, {31'b0, o.ready_after}, 32'd1);
        cmp({tag, ".rfwe_cycle"}, 32'(o.v.rfwe_cycle), 32'(e.rfwe_cycle));
        cmp({tag, ".rfwe_count"}, 32'(o.rfwe_count), (e.rfwe_cycle >= 0) ? 32'd1 : 32'd0);
        if (e.req_first >= 0) begin
            cmp({tag, ".mem_we"}, {31'b0, o.v.we}, {31'b0, e.we});
            cmp({tag, ".mem_addr"}, o.v.addr, e.addr);
            cmp({tag, ".req_stable"}, {31'b0, o.stable}, 32'd1);
            if (e.we) cmp({tag, ".mem_wdata"}, o.v.wdata, e.wdata);
        end
        if (e.rfwe_cycle >= 0) begin
            cmp({tag, ".rf_waddr"}, {27'b0, o.v.waddr}, {27'b0, e.waddr});
            cmp({tag, ".rf_wdata"}, o.v.rf_wdata, e.rf_wdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t        vecs [12];
        obs_t        o;
        exp_t        e;
        logic [31:0] ins;
        logic [5:0]  op;
        logic [15:0] imm;
        int          w;
        bit          sp;

        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 32'h0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 32'h0;

        for (int i = 0; i < 32; i++) rf[i] = $urandom() & 32'hFFFF_FFFC;
        rf[0] = 32'h0;
        rf[1] = 32'h0000_0100;
        rf[2] = 32'hDEAD_BEEF;
        rf[3] = 32'h0000_0200;
        rf[4] = 32'h0000_0101;
        rf[8] = 32'hFFFF_FFFC;
        rf[10] = 32'h0000_0300;
        dmem[32'h1FC] = 32'h1234_5678;
        dmem[32'h204] = 32'hCAFE_0204;
        dmem[32'h004] = 32'h00C0_FFEE;
        dmem[32'h300] = 32'h0BAD_F00D;

        vecs[0]  = '{"sw_basic",     32'hAC22_0008, 0,    1'b0,
                     mk(0, 3, 2, 1, 1'b1, 32'h108, 32'hDEADBEEF, -1, 5'd0, 32'h0)};
        vecs[1]  = '{"lw_3waits",    32'h8C65_FFFC, 3,    1'b0,
                     mk(0, 7, 2, 4, 1'b0, 32'h1FC, 32'h0, 6, 5'd5, 32'h12345678)};
        vecs[2]  = '{"sw_misalign",  32'hAC82_0000, 0,    1'b0,
                     mk(2, 2, -1, 0, 1'b0, 32'h0, 32'h0, -1, 5'd0, 32'h0)};
        vecs[3]  = '{"illegal_op",   32'h2022_0004, 0,    1'b0,
                     mk(1, 2, -1, 0, 1'b0, 32'h0, 32'h0, -1, 5'd0, 32'h0)};
        vecs[4]  = '{"lw_rt0",       32'h8C20_0008, 0,    1'b0,
                     mk(0, 4, 2, 1, 1'b0, 32'h108, 32'h0, -1, 5'd0, 32'h0)};
        vecs[5]  = '{"lw_timeout",   32'h8C66_0000, 1000, 1'b0,
                     mk(3, 17, 2, 15, 1'b0, 32'h200, 32'h0, -1, 5'd0, 32'h0)};
        vecs[6]  = '{"lw_last_ack",  32'h8C67_0004, 14,   1'b0,
                     mk(0, 18, 2, 15, 1'b0, 32'h204, 32'h0, 17, 5'd7, 32'hCAFE0204)};
        vecs[7]  = '{"sw_timeout",   32'hAC22_000C, 15,   1'b0,
                     mk(3, 17, 2, 15, 1'b1, 32'h10C, 32'hDEADBEEF, -1, 5'd0, 32'h0)};
        vecs[8]  = '{"sw_spur_ack",  32'hAC22_FFF8, 2,    1'b1,
                     mk(0, 5, 2, 3, 1'b1, 32'h0F8, 32'hDEADBEEF, -1, 5'd0, 32'h0)};
        vecs[9]  = '{"lw_wrap",      32'h8D09_0008, 0,    1'b0,
                     mk(0, 4, 2, 1, 1'b0, 32'h004, 32'h0, 3, 5'd9, 32'h00C0FFEE)};
        vecs[10] = '{"lw_rs_eq_rt",  32'h8D4A_0000, 1,    1'b0,
                     mk(0, 5, 2, 2, 1'b0, 32'h300, 32'h0, 4, 5'd10, 32'h0BADF00D)};
        vecs[11] = '{"lw_new_base",  32'h8D4B_0000, 0,    1'b0,
                     mk(2, 2, -1, 0, 1'b0, 32'h0, 32'h0, -1, 5'd0, 32'h0)};

        repeat (3) @(negedge clock);
        cmp("reset.instr_ready", {31'b0, instr_ready}, 32'd1);
        cmp("reset.mem_req", {31'b0, mif.mem_req}, 32'd0);
        cmp("reset.mem_we", {31'b0, mif.mem_we}, 32'd0);
        cmp("reset.rf_we", {31'b0, rf_we}, 32'd0);
        cmp("reset.done", {31'b0, done}, 32'd0);
        cmp("reset.err", {30'b0, err}, 32'd0);
        cmp("reset.mem_addr", mif.mem_addr, 32'h0);
        cmp("reset.mem_wdata", mif.mem_wdata, 32'h0);
        cmp("reset.rf_wdata", rf_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            e = ref_model(vecs[i].ins, vecs[i].waits);
            run_op(vecs[i].ins, vecs[i].waits, vecs[i].spur, o);
            check_op(vecs[i].name, o, vecs[i].e);
            apply_ref(e);
        end

        // Reset during the first MEM cycle of a store, then a stray ack.
        instr = 32'hAC22_0010;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        cmp("abort.mem_req_before", {31'b0, mif.mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        cmp("abort.mem_req", {31'b0, mif.mem_req}, 32'd0);
        cmp("abort.done", {31'b0, done}, 32'd0);
        cmp("abort.instr_ready", {31'b0, instr_ready}, 32'd1);
        reset = 1'b0;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'h5555_AAAA;
        @(negedge clock);
        mif.mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmp("abort.late_ack_done", {31'b0, done}, 32'd0);
            cmp("abort.late_ack_req", {31'b0, mif.mem_req}, 32'd0);
            @(negedge clock);
        end
        e = ref_model(32'hAC22_0014, 1);
        run_op(32'hAC22_0014, 1, 1'b0, o);
        check_op("after_abort_sw", o, e);
        apply_ref(e);

        // Randomized traffic against the transaction model.
        for (int i = 1; i < 32; i++) begin
            rf[i] = $urandom();
            if ($urandom_range(0, 4) != 0) rf[i][1:0] = 2'b00;
        end
        for (int k = 0; k < 40; k++) begin
            w = $urandom_range(0, 9);
            op = (w < 5) ? 6'h23 : ((w < 9) ? 6'h2B : 6'($urandom_range(0, 63)));
            imm = 16'($urandom());
            if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
            ins = {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm};
            w = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(13, 17);
            sp = 1'($urandom_range(0, 1));
            e = ref_model(ins, w);
            run_op(ins, w, sp, o);
            check_op($sformatf("rand%0d", k), o, e);
            apply_ref(e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
